cla_byte_serial_ctrl: RTL and testbench
=======================================

// Module: cla_byte_serial_ctrl
// PURPOSE
//  Sequencer that performs a wide (8*NBYTES-bit) addition on one shared external cla_8bit instance.
//  Operands are processed one byte per cycle, least-significant byte first; the carry is registered between bytes.
//  Sits between the Vedic multiplier's partial-product accumulation and the single 8-bit CLA, saving area.
//  The CLA is instantiated outside this block and connected through the cla_* ports.
// PARAMETERS
//  NBYTES  4  number of byte slices per operand (>=2); operand width W = 8*NBYTES
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   synchronous, active-high reset
//  start     in   1   request; sampled only in IDLE
//  A         in   W   operand A, captured on accepted start
//  B         in   W   operand B, captured on accepted start
//  Cin       in   1   carry-in, captured on accepted start
//  busy      out  1   high in RUN and DONE
//  done      out  1   one-cycle pulse: S/Cout are valid
//  S         out  W   registered sum; held until the next accepted start
//  Cout      out  1   registered final carry; held with S
//  cla_A     out  8   byte of A to the CLA
//  cla_B     out  8   byte of B to the CLA
//  cla_Cin   out  1   carry to the CLA
//  cla_S     in   8   CLA sum (combinational return, same cycle)
//  cla_Cout  in   1   CLA carry-out (combinational return, same cycle)
// BEHAVIOUR
//  Reset values: state=IDLE, idx=0, carry_r=0, S=0, Cout=0, busy=0, done=0.
//    cla_A/cla_B/cla_Cin are 0 whenever the state is not RUN.
//  FSM IDLE:
//    - start=1 -> latch A_r<=A, B_r<=B, carry_r<=Cin, idx<=0; go to RUN.
//  FSM RUN:
//    - Combinational CLA drive: cla_A=A_r[8*idx+:8], cla_B=B_r[8*idx+:8], cla_Cin=carry_r.
//    - Registered update: S[8*idx+:8]<=cla_S, carry_r<=cla_Cout.
//    - idx==NBYTES-1 -> Cout<=cla_Cout; go to DONE. Otherwise idx<=idx+1.
//  FSM DONE:
//    - done=1 for exactly this cycle; go to IDLE.
//  Latency: start sampled at edge k; RUN occupies cycles k+1..k+NBYTES; done is high in cycle k+NBYTES+1.
//    Throughput: one operation per NBYTES+2 cycles.
//  start while busy (RUN or DONE) is ignored and not queued; A/B/Cin changes while busy have no effect.
//  Bytes of S not yet written during RUN retain the previous result. S/Cout are valid only from the done cycle on.
//  Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(W+1); no truncation.
//  idx width = clog2(NBYTES); idx never exceeds NBYTES-1.
//  rst at any cycle, including mid-RUN, aborts the operation:
//    - Next cycle all outputs are at reset values; no done pulse is produced.
//    - rst has priority over start in the same cycle.
// CONFIGURATION
//  Macro CLA_SEQ_SUB_EN:
//    - Defined:
//      - Adds input port `sub` (1 bit), captured with start.
//      - When sub=1: B_r<=~B and carry_r<=1, ignoring Cin, giving S=A-B.
//      - Cout=1 means no borrow (A>=B unsigned).
//      - Also adds output `ovf` (1 bit): signed overflow of the W-bit result, registered with Cout, reset 0.
//    - Not defined: no sub/ovf ports; addition only.
// TESTING (NBYTES=4 unless stated)
//  1. A=0x000000FF, B=0x00000001, Cin=0, start at edge k
//     -> done at cycle k+5, S=0x00000100, Cout=0; busy high cycles k+1..k+5.
//  2. A=0xFFFFFFFF, B=0x00000000, Cin=1 -> S=0x00000000, Cout=1 (carry ripples through all 4 bytes).
//  3. Start op A=1, B=2; assert start again with A=9, B=9 in RUN cycle 2
//     -> single done pulse, S=0x00000003; no second operation occurs.
//  4. rst=1 in RUN cycle 2 -> next cycle busy=0, done=0, S=0, Cout=0, cla_*=0;
//     then A=0x12345678, B=0x11111111 -> S=0x23456789, Cout=0.
//  5. CLA_SEQ_SUB_EN defined:
//     - A=5, B=7, sub=1 -> S=0xFFFFFFFE, Cout=0, ovf=0.
//     - A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, Cout=1, ovf=1.
//  6. NBYTES=2 and NBYTES=4: 1000 random {A,B,Cin}, back-to-back starts asserted in the cycle after done
//     -> {Cout,S} == A+B+Cin on every done pulse.

Source files
------------

// File: rtl/cla_byte_serial_ctrl.sv
// cla_byte_serial_ctrl
//   Sequences a W = 8*NBYTES bit addition through one shared external 8-bit CLA.
//   It handles one byte per cycle, least-significant byte first. The carry is held
//   in a register between bytes.
//
// Optional feature (macro CLA_SEQ_SUB_EN):
//   Adds the `sub` input, which requests S = A - B.
//   Also adds the `ovf` output, the signed overflow of the W-bit result.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   A, B, Cin         operands, captured when start is accepted
//   busy              high in RUN and DONE
//   done              one-cycle pulse, S/Cout valid
//   S, Cout           registered result, held until the next accepted start
//   cla_A/B/Cin       byte operands to the external CLA (zero outside RUN)
//   cla_S, cla_Cout   combinational return from the external CLA
//   sub, ovf          subtract request / signed overflow (CLA_SEQ_SUB_EN only)
module cla_byte_serial_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  Cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   S,
    output logic                  Cout,
    output logic [7:0]            cla_A,
    output logic [7:0]            cla_B,
    output logic                  cla_Cin,
    input  logic [7:0]            cla_S,
    input  logic                  cla_Cout
`ifdef CLA_SEQ_SUB_EN
    ,
    input  logic                  sub,
    output logic                  ovf
`endif
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [IW+2:0]   lo;

    // Bit offset of the current byte slice
    assign lo = {idx, 3'b000};

    // CLA operand drive; quiet outside RUN
    always_comb begin
        cla_A   = '0;
        cla_B   = '0;
        cla_Cin = 1'b0;
        if (state == RUN) begin
            cla_A   = a_r[lo +: 8];
            cla_B   = b_r[lo +: 8];
            cla_Cin = carry_r;
        end
    end

    // Sequencer state, operand capture and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
`ifdef CLA_SEQ_SUB_EN
                        // Two's-complement subtract: invert B and force the carry-in
                        b_r     <= sub ? ~B : B;
                        carry_r <= sub ? 1'b1 : Cin;
`else
                        b_r     <= B;
                        carry_r <= Cin;
`endif
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[lo +: 8] <= cla_S;
                    carry_r    <= cla_Cout;
                    if (idx == LAST) begin
                        Cout  <= cla_Cout;
`ifdef CLA_SEQ_SUB_EN
                        // Overflow: both operand signs equal but the result sign differs
                        ovf   <= (a_r[W-1] ~^ b_r[W-1]) & (cla_S[7] ^ a_r[W-1]);
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_byte_serial_ctrl.sv
// Bench for cla_byte_serial_ctrl. It holds one NBYTES=4 instance and one NBYTES=2 instance.
// Each instance has its own behavioural 8-bit CLA and its own expected-result queue.
module tb_cla_byte_serial_ctrl;

    localparam int unsigned NB4 = 4;
    localparam int unsigned W4  = 32;
    localparam int unsigned NB2 = 2;
    localparam int unsigned W2  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          start4, cin4, busy4, done4, cout4, cla_cin4, cla_cout4;
    logic [W4-1:0] a4, b4, s4;
    logic [7:0]    cla_a4, cla_b4, cla_s4;

    logic          start2, cin2, busy2, done2, cout2, cla_cin2, cla_cout2;
    logic [W2-1:0] a2, b2, s2;
    logic [7:0]    cla_a2, cla_b2, cla_s2;

`ifdef CLA_SEQ_SUB_EN
    logic sub4, ovf4, sub2, ovf2;
`endif

    // Behavioural stand-ins for the external 8-bit CLAs
    assign {cla_cout4, cla_s4} = 9'(cla_a4) + 9'(cla_b4) + 9'(cla_cin4);
    assign {cla_cout2, cla_s2} = 9'(cla_a2) + 9'(cla_b2) + 9'(cla_cin2);

    cla_byte_serial_ctrl #(.NBYTES(NB4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .S(s4), .Cout(cout4),
        .cla_A(cla_a4), .cla_B(cla_b4), .cla_Cin(cla_cin4),
        .cla_S(cla_s4), .cla_Cout(cla_cout4)
`ifdef CLA_SEQ_SUB_EN
        , .sub(sub4), .ovf(ovf4)
`endif
    );

    cla_byte_serial_ctrl #(.NBYTES(NB2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
        .busy(busy2), .done(done2), .S(s2), .Cout(cout2),
        .cla_A(cla_a2), .cla_B(cla_b2), .cla_Cin(cla_cin2),
        .cla_S(cla_s2), .cla_Cout(cla_cout2)
`ifdef CLA_SEQ_SUB_EN
        , .sub(sub2), .ovf(ovf2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] q4[$];
    logic [33:0] q2[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result packed as {ovf, cout, s} with s in bits w-1:0
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sb, input int w);
        logic [32:0] mask, bb, full;
        logic        ovf;
        logic [33:0] r;
        mask = (33'h1 << w) - 33'h1;
        bb   = (sb ? {1'b0, ~b} : {1'b0, b}) & mask;
        full = ({1'b0, a} & mask) + bb + 33'(sb ? 1'b1 : cin);
        ovf  = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
        r    = 34'(full & ((mask << 1) | 33'h1));
        r    = r | (34'(ovf) << (w + 1));
        return r;
    endfunction

    // Result monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                check("spurious_done4", 64'(done4), 64'(0));
            end else begin
                logic [33:0] e;
                e = q4.pop_front();
                check("sum4", 64'(s4), 64'(e[31:0]));
                check("cout4", 64'(cout4), 64'(e[32]));
`ifdef CLA_SEQ_SUB_EN
                check("ovf4", 64'(ovf4), 64'(e[33]));
`endif
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                check("spurious_done2", 64'(done2), 64'(0));
            end else begin
                logic [33:0] e;
                e = q2.pop_front();
                check("sum2", 64'(s2), 64'(e[15:0]));
                check("cout2", 64'(cout2), 64'(e[16]));
            end
        end
    end

    // One operation on dut4. mode 0: plain, 1: extra start in RUN cycle 2, 2: reset in RUN cycle 2.
    // Called at posedge+1 with the DUT idle and returns at posedge+1 of the cycle after done.
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sb, input int mode);
        int lat;
        lat = 0;
        start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
`ifdef CLA_SEQ_SUB_EN
        sub4 = sb;
`endif
        if (mode != 2) q4.push_back(model(a, b, cin, sb, 32));
        @(posedge clk); #1;
        start4 = 1'b0; a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
        for (int c = 1; c <= int'(NB4) + 4; c++) begin
            start4 = 1'b0;
            if (mode == 1 && c == 2) begin
                start4 = 1'b1; a4 = 32'd9; b4 = 32'd9;
            end
            if (mode == 2 && c == 2) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_busy", 64'(busy4), 64'(0));
                check("rst_done", 64'(done4), 64'(0));
                check("rst_s", 64'(s4), 64'(0));
                check("rst_cout", 64'(cout4), 64'(0));
                check("rst_cla", {cla_cin4, cla_a4, cla_b4}, 64'(0));
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (c == 1) begin
                check("cla_a_lsb", 64'(cla_a4), 64'(a[7:0]));
                check("cla_b_lsb", 64'(cla_b4), sb ? 64'(~b[7:0]) : 64'(b[7:0]));
                check("cla_cin_lsb", 64'(cla_cin4), 64'(sb ? 1'b1 : cin));
            end
            check("busy4", 64'(busy4), 64'(1));
            if (done4) begin
                lat = c;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        check("latency4", 64'(lat), 64'(NB4 + 1));
    endtask

    // Back-to-back operation on dut2 with the latency check
    task automatic op2(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int lat;
        lat = 0;
        start2 = 1'b1; a2 = a; b2 = b; cin2 = cin;
        q2.push_back(model({16'h0, a}, {16'h0, b}, cin, 1'b0, 16));
        @(posedge clk); #1;
        start2 = 1'b0; a2 = 16'($urandom); b2 = 16'($urandom);
        for (int c = 1; c <= int'(NB2) + 4; c++) begin
            @(negedge clk);
            if (done2) begin
                lat = c;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        check("latency2", 64'(lat), 64'(NB2 + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub4 = 1'b0; sub2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy4), 64'(0));
        check("reset_done", 64'(done4), 64'(0));
        check("reset_s", 64'(s4), 64'(0));
        check("reset_cout", 64'(cout4), 64'(0));
        check("reset_cla", {cla_cin4, cla_a4, cla_b4}, 64'(0));
        @(posedge clk); #1;

        // Carry out of the low byte
        op4(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("idle_busy", 64'(busy4), 64'(0));
        check("idle_done", 64'(done4), 64'(0));
        @(posedge clk); #1;

        // Carry ripples through every byte
        op4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);

        // Start while busy is ignored; the monitor flags any extra done
        op4(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1);
        repeat (NB4 + 3) @(posedge clk);
        #1;
        check("no_second_op", 64'(busy4), 64'(0));

        // Abort mid-run, then a fresh operation
        op4(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 2);
        op4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
        op4(32'd5, 32'd7, 1'b0, 1'b1, 0);
        op4(32'h8000_0000, 32'd1, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 1000; i++) begin
            op4($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 0);
        end
        for (int i = 0; i < 1000; i++) begin
            op2(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (8) @(posedge clk);
        #1;
        check("q4_drained", 64'(q4.size()), 64'(0));
        check("q2_drained", 64'(q2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
